// File: rtl/lpddr3_dqs_eye_tracker.sv
// Closed-loop DQS delay-line tracker for one LPDDR3 lane: votes EARLY/LATE flags over a
// sampling window and steps the IOD delay line one tap at a time until the strobe is centred.
module lpddr3_dqs_eye_tracker #(
    parameter int TAP_W      = 8,
    parameter int MAX_TAP    = 255,
    parameter int SETTLE_CYC = 8,
    parameter int SAMPLE_WIN = 16,
    parameter int VOTE_TH    = 4,
    parameter int LOCK_CNT   = 2
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             en,
    input  logic             load_req,
    input  logic             eye_early,
    input  logic             eye_late,
    input  logic             dly_oor,
    output logic             clear_flags,
    output logic             dly_move,
    output logic             dly_dir,
    output logic             dly_load,
    output logic [TAP_W-1:0] tap_pos,
    output logic             locked,
    output logic             err_oor,
    output logic             busy
);

    localparam int CNT_W   = $clog2(SAMPLE_WIN + 1);
    localparam int TMR_MAX = (SETTLE_CYC > SAMPLE_WIN) ? SETTLE_CYC : SAMPLE_WIN;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RUN_W   = $clog2(LOCK_CNT + 1);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] SAMPLE_LAST = TMR_W'(SAMPLE_WIN - 1);
    localparam logic [CNT_W:0]   VOTE        = (CNT_W + 1)'(VOTE_TH);
    localparam logic [TAP_W-1:0] TAP_TOP     = TAP_W'(MAX_TAP);
    localparam logic [RUN_W-1:0] RUN_TOP     = RUN_W'(LOCK_CNT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DECIDE = 3'd5,
        ST_MOVE   = 3'd6
    } state_t;

    state_t             state_r;
    logic [TMR_W-1:0]   tmr_r;
    logic [CNT_W-1:0]   early_cnt_r;
    logic [CNT_W-1:0]   late_cnt_r;
    logic [RUN_W-1:0]   run_cnt_r;
    logic               clear_flags_r;
    logic               dly_move_r;
    logic               dly_dir_r;
    logic               dly_load_r;
    logic [TAP_W-1:0]   tap_pos_r;
    logic               locked_r;
    logic               err_oor_r;
    logic               busy_r;

    logic [CNT_W:0]     early_ext_s;
    logic [CNT_W:0]     late_ext_s;
    logic               want_up_s;
    logic               want_dn_s;
    logic               at_limit_s;

    // Vote evaluation; counters are widened by one bit so the threshold sum cannot wrap.
    always_comb begin
        early_ext_s = {1'b0, early_cnt_r};
        late_ext_s  = {1'b0, late_cnt_r};
        want_up_s   = (early_ext_s >= (late_ext_s + VOTE));
        want_dn_s   = (late_ext_s >= (early_ext_s + VOTE));
        if (want_up_s) begin
            at_limit_s = (tap_pos_r == TAP_TOP);
        end else begin
            at_limit_s = (tap_pos_r == {TAP_W{1'b0}});
        end
    end

    // Tracking FSM; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_r       <= ST_IDLE;
            tmr_r         <= {TMR_W{1'b0}};
            early_cnt_r   <= {CNT_W{1'b0}};
            late_cnt_r    <= {CNT_W{1'b0}};
            run_cnt_r     <= {RUN_W{1'b0}};
            clear_flags_r <= 1'b0;
            dly_move_r    <= 1'b0;
            dly_dir_r     <= 1'b0;
            dly_load_r    <= 1'b0;
            tap_pos_r     <= {TAP_W{1'b0}};
            locked_r      <= 1'b0;
            err_oor_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            clear_flags_r <= 1'b0;
            dly_move_r    <= 1'b0;
            dly_load_r    <= 1'b0;
            if (load_req) begin
                state_r    <= ST_LOAD;
                dly_load_r <= 1'b1;
                tap_pos_r  <= {TAP_W{1'b0}};
                locked_r   <= 1'b0;
                err_oor_r  <= 1'b0;
                run_cnt_r  <= {RUN_W{1'b0}};
                busy_r     <= 1'b1;
            end else if (dly_oor && (state_r != ST_IDLE) && (state_r != ST_LOAD)) begin
                state_r   <= ST_IDLE;
                err_oor_r <= 1'b1;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (en && !err_oor_r) begin
                            state_r       <= ST_CLEAR;
                            clear_flags_r <= 1'b1;
                            early_cnt_r   <= {CNT_W{1'b0}};
                            late_cnt_r    <= {CNT_W{1'b0}};
                            busy_r        <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        state_r       <= ST_CLEAR;
                        clear_flags_r <= 1'b1;
                        early_cnt_r   <= {CNT_W{1'b0}};
                        late_cnt_r    <= {CNT_W{1'b0}};
                    end
                    ST_CLEAR: begin
                        if (!en) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_SETTLE;
                            tmr_r   <= {TMR_W{1'b0}};
                        end
                    end
                    ST_SETTLE: begin
                        if (!en) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else if (tmr_r == SETTLE_LAST) begin
                            state_r <= ST_SAMPLE;
                            tmr_r   <= {TMR_W{1'b0}};
                        end else begin
                            tmr_r <= tmr_r + TMR_W'(1);
                        end
                    end
                    ST_SAMPLE: begin
                        if (!en) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            early_cnt_r <= early_cnt_r + CNT_W'(eye_early);
                            late_cnt_r  <= late_cnt_r + CNT_W'(eye_late);
                            if (tmr_r == SAMPLE_LAST) begin
                                state_r <= ST_DECIDE;
                            end else begin
                                tmr_r <= tmr_r + TMR_W'(1);
                            end
                        end
                    end
                    ST_DECIDE: begin
                        if (!en) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else if (want_up_s || want_dn_s) begin
                            if (at_limit_s) begin
                                state_r   <= ST_IDLE;
                                err_oor_r <= 1'b1;
                                busy_r    <= 1'b0;
                            end else begin
                                state_r    <= ST_MOVE;
                                dly_move_r <= 1'b1;
                                dly_dir_r  <= want_up_s;
                                tap_pos_r  <= want_up_s ? (tap_pos_r + TAP_W'(1))
                                                        : (tap_pos_r - TAP_W'(1));
                                locked_r   <= 1'b0;
                                run_cnt_r  <= {RUN_W{1'b0}};
                            end
                        end else begin
                            // Eye balanced: count consecutive quiet decisions towards lock.
                            if (run_cnt_r != RUN_TOP) begin
                                run_cnt_r <= run_cnt_r + RUN_W'(1);
                            end
                            if (run_cnt_r >= (RUN_TOP - RUN_W'(1))) begin
                                locked_r <= 1'b1;
                            end
                            state_r       <= ST_CLEAR;
                            clear_flags_r <= 1'b1;
                            early_cnt_r   <= {CNT_W{1'b0}};
                            late_cnt_r    <= {CNT_W{1'b0}};
                        end
                    end
                    ST_MOVE: begin
                        if (!en) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r       <= ST_CLEAR;
                            clear_flags_r <= 1'b1;
                            early_cnt_r   <= {CNT_W{1'b0}};
                            late_cnt_r    <= {CNT_W{1'b0}};
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign clear_flags = clear_flags_r;
    assign dly_move    = dly_move_r;
    assign dly_dir     = dly_dir_r;
    assign dly_load    = dly_load_r;
    assign tap_pos     = tap_pos_r;
    assign locked      = locked_r;
    assign err_oor     = err_oor_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_lpddr3_dqs_eye_tracker.sv
// Directed bench for the DQS eye tracker: an iteration-position reference model is compared
// with the DUT on every falling edge, with literal checks on the headline timing points.
module tb_lpddr3_dqs_eye_tracker;

    localparam int S_CYC = 8;
    localparam int W_CYC = 16;
    localparam int TH    = 4;
    localparam int LOCKN = 2;
    localparam int P_DEC = S_CYC + W_CYC + 1;
    localparam int P_MV  = S_CYC + W_CYC + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load_req = 1'b0;
    logic       eye_early = 1'b0;
    logic       eye_late = 1'b0;
    logic       dly_oor = 1'b0;
    logic       clear_flags, dly_move, dly_dir, dly_load, locked, err_oor, busy;
    logic [7:0] tap_pos;

    int total = 0;
    int bad = 0;
    bit alt = 1'b0;

    lpddr3_dqs_eye_tracker dut (
        .FAB_CLK(clk), .ARST_N(rst_n), .en(en), .load_req(load_req),
        .eye_early(eye_early), .eye_late(eye_late), .dly_oor(dly_oor),
        .clear_flags(clear_flags), .dly_move(dly_move), .dly_dir(dly_dir),
        .dly_load(dly_load), .tap_pos(tap_pos), .locked(locked),
        .err_oor(err_oor), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: m_ph is cycles since the iteration's clear (-1 = load cycle).
    bit m_act = 1'b0;
    int m_ph = 0;
    int m_tap = 0;
    bit m_locked = 1'b0;
    bit m_err = 1'b0;
    int m_run = 0;
    bit m_dir = 1'b0;
    int m_e = 0;
    int m_l = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_ph = 0; m_tap = 0; m_locked = 0; m_err = 0;
            m_run = 0; m_dir = 0; m_e = 0; m_l = 0;
        end else if (load_req) begin
            m_act = 1; m_ph = -1; m_tap = 0; m_locked = 0; m_err = 0; m_run = 0;
        end else if (m_act && m_ph != -1 && dly_oor) begin
            m_err = 1; m_act = 0;
        end else if (!m_act) begin
            if (en && !m_err) begin
                m_act = 1; m_ph = 0; m_e = 0; m_l = 0;
            end
        end else if (m_ph == -1) begin
            m_ph = 0; m_e = 0; m_l = 0;
        end else if (!en) begin
            m_act = 0;
        end else if (m_ph == P_MV) begin
            m_ph = 0; m_e = 0; m_l = 0;
        end else if (m_ph == P_DEC) begin
            int diff;
            bit up;
            diff = m_e - m_l;
            if (diff >= TH || -diff >= TH) begin
                up = (diff > 0);
                if ((up && m_tap == 255) || (!up && m_tap == 0)) begin
                    m_err = 1; m_act = 0;
                end else begin
                    m_dir = up;
                    m_tap = up ? m_tap + 1 : m_tap - 1;
                    m_locked = 0; m_run = 0; m_ph = P_MV;
                end
            end else begin
                if (m_run < LOCKN) m_run++;
                if (m_run >= LOCKN) m_locked = 1;
                m_ph = 0; m_e = 0; m_l = 0;
            end
        end else begin
            if (m_ph > S_CYC) begin
                m_e += int'(eye_early);
                m_l += int'(eye_late);
            end
            m_ph++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Cycle-by-cycle comparison against the reference.
    always @(negedge clk) begin
        chk("cmp_clear", 32'(clear_flags), 32'(m_act && m_ph == 0));
        chk("cmp_load",  32'(dly_load),    32'(m_act && m_ph == -1));
        chk("cmp_move",  32'(dly_move),    32'(m_act && m_ph == P_MV));
        chk("cmp_dir",   32'(dly_dir),     32'(m_dir));
        chk("cmp_tap",   32'(tap_pos),     32'(m_tap));
        chk("cmp_lock",  32'(locked),      32'(m_locked));
        chk("cmp_err",   32'(err_oor),     32'(m_err));
        chk("cmp_busy",  32'(busy),        32'(m_act));
    end

    task automatic step();
        @(negedge clk);
        if (alt) begin
            eye_early = ~eye_early;
            eye_late  = ~eye_early;
        end
    endtask

    task automatic wait_move(input string nm, input int bound, output int n);
        n = 0;
        step();
        while (!dly_move && n < bound) begin
            step();
            n++;
        end
        if (!dly_move) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic all_zero(input string nm);
        chk(nm, {24'd0, clear_flags, dly_move, dly_dir, dly_load, locked, err_oor, busy, 1'b0}, 32'd0);
        chk({nm, "_tap"}, 32'(tap_pos), 32'd0);
    endtask

    initial begin
        int n, last, first_clr, moves;
        repeat (3) step();
        all_zero("reset_outs");
        rst_n = 1'b1;
        step();

        // 1: load pulse, then one clear pulse
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("t1_load", 32'(dly_load), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_tap", 32'(tap_pos), 32'd0);
        step();
        chk("t1_clear", 32'(clear_flags), 32'd1);
        chk("t1_load_off", 32'(dly_load), 32'd0);
        step();

        // 2: early held -> moves up every 27 cycles
        en = 1'b1; eye_early = 1'b1;
        moves = 0; last = 0;
        for (int i = 1; i <= 120 && moves < 3; i++) begin
            step();
            if (dly_move) begin
                moves++;
                chk("t2_tap", 32'(tap_pos), 32'(moves));
                chk("t2_dir", 32'(dly_dir), 32'd1);
                chk("t2_lock", 32'(locked), 32'd0);
                if (moves == 1) chk("t2_first", 32'(i), 32'd27);
                else chk("t2_period", 32'(i - last), 32'd27);
                last = i;
            end
        end
        chk("t2_moves", 32'(moves), 32'd3);

        // 3: alternating flags -> no move, locked 52 cycles after the first clear
        eye_early = 1'b0; eye_late = 1'b1; alt = 1'b1;
        first_clr = -1; moves = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (dly_move) moves++;
            if (clear_flags && first_clr < 0) first_clr = i;
            if (locked) begin
                chk("t3_lock_time", 32'(i - first_clr), 32'd52);
                break;
            end
        end
        chk("t3_locked", 32'(locked), 32'd1);
        chk("t3_nomove", 32'(moves), 32'd0);
        chk("t3_tap", 32'(tap_pos), 32'd3);

        // 4: late held at tap 0 -> range error, no pulse, sticky
        alt = 1'b0; eye_early = 1'b0; eye_late = 1'b1;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        moves = 0; n = 0;
        while (!err_oor && n < 60) begin
            step();
            if (dly_move) moves++;
            n++;
        end
        chk("t4_err", 32'(err_oor), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_nomove", 32'(moves), 32'd0);
        chk("t4_tap", 32'(tap_pos), 32'd0);
        repeat (5) step();
        chk("t4_sticky", 32'(err_oor), 32'd1);
        chk("t4_idle", 32'(busy), 32'd0);

        // 4b: climb to MAX_TAP, then error at the top limit
        eye_early = 1'b1; eye_late = 1'b0;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        n = 0;
        while (!err_oor && n < 8000) begin
            step();
            n++;
        end
        chk("t4b_err", 32'(err_oor), 32'd1);
        chk("t4b_tap", 32'(tap_pos), 32'd255);
        chk("t4b_busy", 32'(busy), 32'd0);

        // 5a: en dropped in SETTLE keeps tap_pos; en back gives clear on the next clock
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("t5_err_clr", 32'(err_oor), 32'd0);
        wait_move("t5_move", 40, n);
        chk("t5_tap1", 32'(tap_pos), 32'd1);
        eye_early = 1'b0;
        step();
        chk("t5_clr", 32'(clear_flags), 32'd1);
        repeat (3) step();
        en = 1'b0;
        step();
        chk("t5_en_idle", 32'(busy), 32'd0);
        chk("t5_tap_kept", 32'(tap_pos), 32'd1);
        repeat (2) step();
        chk("t5_no_clear", 32'(clear_flags), 32'd0);
        en = 1'b1;
        step();
        chk("t5_en_clear", 32'(clear_flags), 32'd1);
        // 5b: dly_oor in SAMPLE
        repeat (12) step();
        dly_oor = 1'b1;
        step();
        dly_oor = 1'b0;
        chk("t5_oor_err", 32'(err_oor), 32'd1);
        chk("t5_oor_busy", 32'(busy), 32'd0);

        // 6: load_req during SAMPLE, then async reset during MOVE
        eye_early = 1'b1;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        step();
        chk("t6_clear", 32'(clear_flags), 32'd1);
        repeat (12) step();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        chk("t6_abort_load", 32'(dly_load), 32'd1);
        chk("t6_abort_tap", 32'(tap_pos), 32'd0);
        wait_move("t6_move", 40, n);
        chk("t6_in_move", 32'(dly_move), 32'd1);
        #2 rst_n = 1'b0;
        #1 all_zero("t6_arst");
        repeat (2) step();
        rst_n = 1'b1;
        en = 1'b0;
        step();
        all_zero("t6_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
